// File: rtl/mult_pkg.sv
// Shared types and default sizing for the Robertson multiplier and its result collector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_pkg;

   // Width of the signed product produced by the multiplier.
   localparam int PROD_W = 16;

   // Default collector sizing, shared with the multiplier top level and the bench.
   localparam int DEF_DEPTH = 4;
   localparam int DEF_ACC_W = 20;

   typedef logic signed [PROD_W-1:0] prod_t;

endpackage : mult_pkg

// File: rtl/mult_fifo.sv
// Small synchronous show-ahead FIFO of signed products with a synchronous flush.
// Latency: a push is visible on dout one cycle later; a pop exposes the next entry one cycle later.
// Backpressure: push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, din        write din at the clock edge
//   pop              retire the head entry at the clock edge
//   flush            synchronous empty (pointers and count to zero), wins over push/pop
//   dout             head entry, zero when empty
//   count            current occupancy, 0..DEPTH
module mult_fifo
   import mult_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  prod_t                    din,
   input  logic                     pop,
   input  logic                     flush,
   output prod_t                    dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   prod_t          mem_q [DEPTH];
   prod_t          mem_d [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q,  count_d;

   logic           empty;
   logic           full;
   logic           do_pop;
   logic           do_push;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_FULL);

   // A pop frees the slot the push would need, so a full FIFO still accepts
   // a push when it is popped in the same cycle. When full, wr_ptr == rd_ptr:
   // the head is read combinationally before the edge overwrites that slot.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Head is forced to zero when empty so stale entries never leak out.
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];
   assign count = count_q;

endmodule : mult_fifo

// File: rtl/mult_result_collector.sv
// Captures each completed multiplier product once, queues it for a consumer and keeps a saturating running sum.
// Latency: a captured product appears on out_data/out_valid one cycle after the capturing edge.
// Backpressure: out_ready gates pops; a capture into a full, un-popped FIFO is dropped and flagged on ovf.
//
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   product, done                  multiplier result and its level completion flag
//   clr                            synchronous clear of FIFO, accumulator and sticky flags
//   out_data, out_valid, out_ready head of FIFO with valid/ready handshake
//   acc, acc_sat                   saturating signed sum of captures, sticky clamp flag
//   ovf                            sticky: a capture was dropped on a full FIFO
//   count                          FIFO occupancy
module mult_result_collector
   import mult_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  prod_t                      product,
   input  logic                       done,
   input  logic                       clr,
   output prod_t                      out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [ACC_W-1:0]    acc,
   output logic                       acc_sat,
   output logic                       ovf,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   // Clamp limits, expressed at the widened sum width and at the accumulator width.
   localparam logic signed [ACC_W:0]   SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W:0]   SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic                     done_q,    done_d;
   logic signed [ACC_W-1:0]  acc_q,     acc_d;
   logic                     acc_sat_q, acc_sat_d;
   logic                     ovf_q,     ovf_d;

   logic                     cap;
   logic                     pop;
   logic                     push;
   logic                     drop;
   logic                     fifo_full;
   logic signed [ACC_W:0]    sum;
   prod_t                    fifo_dout;
   logic [CW-1:0]            fifo_count;

   // done is a level that stays high until the next multiply starts, so only
   // its rising edge is a new result. done_q resets high so a done already
   // asserted when reset releases is treated as old and not captured.
   assign done_d = done;
   assign cap    = done & ~done_q;

   assign out_valid = (fifo_count != '0);
   assign fifo_full = (fifo_count == CNT_FULL);
   assign pop       = out_valid & out_ready;

   // clr discards the capture, but done_q above still tracks done, so the
   // edge is consumed and does not resurface after clr drops.
   assign push = cap & ~clr & (~fifo_full | pop);
   assign drop = cap & ~clr & fifo_full & ~pop;

   // One spare bit of headroom makes overflow of a single add detectable.
   assign sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(product);

   always_comb begin
      acc_d     = acc_q;
      acc_sat_d = acc_sat_q;
      ovf_d     = ovf_q;

      if (clr) begin
         acc_d     = '0;
         acc_sat_d = 1'b0;
         ovf_d     = 1'b0;
      end else begin
         // Dropped captures still count toward the running sum.
         if (cap) begin
            if (sum > SUM_MAX) begin
               acc_d     = ACC_MAX;
               acc_sat_d = 1'b1;
            end else if (sum < SUM_MIN) begin
               acc_d     = ACC_MIN;
               acc_sat_d = 1'b1;
            end else begin
               acc_d     = sum[ACC_W-1:0];
            end
         end
         if (drop) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q    <= 1'b1;
         acc_q     <= '0;
         acc_sat_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         done_q    <= done_d;
         acc_q     <= acc_d;
         acc_sat_q <= acc_sat_d;
         ovf_q     <= ovf_d;
      end
   end

   mult_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push),
      .din   (product),
      .pop   (pop),
      .flush (clr),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   assign out_data = fifo_dout;
   assign count    = fifo_count;
   assign acc      = acc_q;
   assign acc_sat  = acc_sat_q;
   assign ovf      = ovf_q;

endmodule : mult_result_collector

// File: tb/tb_mult_result_collector.sv
// Directed self-checking bench for mult_result_collector at DEPTH=4, ACC_W=20.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Each scenario task checks its own expectations inline.
module tb_mult_result_collector;
   import mult_pkg::*;

   localparam int DEPTH = DEF_DEPTH;
   localparam int ACC_W = DEF_ACC_W;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic                     clk = 1'b0;
   logic                     reset;
   logic signed [15:0]       product;
   logic                     done;
   logic                     clr;
   logic signed [15:0]       out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [ACC_W-1:0]  acc;
   logic                     acc_sat;
   logic                     ovf;
   logic [CW-1:0]            count;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   mult_result_collector #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .product   (product),
      .done      (done),
      .clr       (clr),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc       (acc),
      .acc_sat   (acc_sat),
      .ovf       (ovf),
      .count     (count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One done rising edge with the given product, then done low for a cycle.
   task automatic pulse(input logic signed [15:0] p);
      product = p;
      done    = 1'b1;
      tick();
      done    = 1'b0;
      tick();
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b0; product = '0; done = 1'b0; clr = 1'b0; out_ready = 1'b0;
      #12;
      vec_cnt++; if (out_valid !== 1'b0) begin $display("FAIL reset_valid: got %0b want 0", out_valid); err_cnt++; end
      vec_cnt++; if (out_data !== 16'sd0) begin $display("FAIL reset_data: got %0d want 0", out_data); err_cnt++; end
      vec_cnt++; if (count !== 3'd0) begin $display("FAIL reset_count: got %0d want 0", count); err_cnt++; end
      vec_cnt++; if (acc !== 20'sd0) begin $display("FAIL reset_acc: got %0d want 0", acc); err_cnt++; end
      vec_cnt++; if (acc_sat !== 1'b0 || ovf !== 1'b0) begin $display("FAIL reset_flags: got sat=%0b ovf=%0b want 0 0", acc_sat, ovf); err_cnt++; end
      reset = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_edge_capture();
      logic signed [15:0] exp_q [2];
      exp_q[0] = -16'sd3;
      exp_q[1] = 16'sd7;
      product = 16'hFFFD;
      done    = 1'b1;
      repeat (10) tick();
      done = 1'b0;
      tick();
      vec_cnt++; if (count !== 3'd1) begin $display("FAIL edge_held_count: got %0d want 1", count); err_cnt++; end
      pulse(16'sd7);
      vec_cnt++; if (count !== 3'd2) begin $display("FAIL edge_count: got %0d want 2", count); err_cnt++; end
      vec_cnt++; if (acc !== 20'sd4) begin $display("FAIL edge_acc: got %0d want 4", acc); err_cnt++; end
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         vec_cnt++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin $display("FAIL edge_pop%0d: got v=%0b d=%0d want v=1 d=%0d", i, out_valid, out_data, exp_q[i]); err_cnt++; end
         tick();
      end
      out_ready = 1'b0;
      vec_cnt++; if (count !== 3'd0 || out_valid !== 1'b0) begin $display("FAIL edge_drained: got count=%0d v=%0b want 0 0", count, out_valid); err_cnt++; end
   endtask

   task automatic test_full_overflow();
      do_clr();
      for (int i = 1; i <= 5; i++) begin
         pulse(16'(i));
         if (i == 4) begin
            vec_cnt++; if (ovf !== 1'b0 || count !== 3'd4) begin $display("FAIL full_at4: got ovf=%0b count=%0d want 0 4", ovf, count); err_cnt++; end
         end
      end
      vec_cnt++; if (count !== 3'd4) begin $display("FAIL full_count: got %0d want 4", count); err_cnt++; end
      vec_cnt++; if (ovf !== 1'b1) begin $display("FAIL full_ovf: got %0b want 1", ovf); err_cnt++; end
      vec_cnt++; if (acc !== 20'sd15) begin $display("FAIL full_acc: got %0d want 15", acc); err_cnt++; end
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         vec_cnt++; if (out_data !== 16'(i)) begin $display("FAIL full_pop%0d: got %0d want %0d", i, out_data, i); err_cnt++; end
         tick();
      end
      out_ready = 1'b0;
      vec_cnt++; if (out_valid !== 1'b0) begin $display("FAIL full_drained: got %0b want 0", out_valid); err_cnt++; end
   endtask

   task automatic test_push_pop_full();
      logic signed [15:0] exp_q [4];
      exp_q[0] = 16'sd2; exp_q[1] = 16'sd3; exp_q[2] = 16'sd4; exp_q[3] = 16'sd9;
      do_clr();
      for (int i = 1; i <= 4; i++) pulse(16'(i));
      product   = 16'sd9;
      done      = 1'b1;
      out_ready = 1'b1;
      vec_cnt++; if (out_data !== 16'sd1) begin $display("FAIL pp_head: got %0d want 1", out_data); err_cnt++; end
      tick();
      out_ready = 1'b0;
      done      = 1'b0;
      vec_cnt++; if (count !== 3'd4 || ovf !== 1'b0) begin $display("FAIL pp_count_ovf: got count=%0d ovf=%0b want 4 0", count, ovf); err_cnt++; end
      vec_cnt++; if (acc !== 20'sd19) begin $display("FAIL pp_acc: got %0d want 19", acc); err_cnt++; end
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vec_cnt++; if (out_data !== exp_q[i]) begin $display("FAIL pp_pop%0d: got %0d want %0d", i, out_data, exp_q[i]); err_cnt++; end
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_saturation();
      do_clr();
      for (int i = 0; i < 16; i++) pulse(16'sd32767);
      vec_cnt++; if (acc !== 20'sd524272 || acc_sat !== 1'b0) begin $display("FAIL sat_16: got acc=%0d sat=%0b want 524272 0", acc, acc_sat); err_cnt++; end
      pulse(16'sd32767);
      vec_cnt++; if (acc !== 20'sd524287) begin $display("FAIL sat_acc: got %0d want 524287", acc); err_cnt++; end
      vec_cnt++; if (acc_sat !== 1'b1) begin $display("FAIL sat_flag: got %0b want 1", acc_sat); err_cnt++; end
      do_clr();
      vec_cnt++; if (acc !== 20'sd0 || acc_sat !== 1'b0 || count !== 3'd0 || ovf !== 1'b0) begin $display("FAIL sat_clr: got acc=%0d sat=%0b count=%0d ovf=%0b want 0 0 0 0", acc, acc_sat, count, ovf); err_cnt++; end
   endtask

   task automatic test_neg_saturation();
      logic signed [ACC_W-1:0] acc_min;
      acc_min = 20'h80000;
      do_clr();
      for (int i = 0; i < 16; i++) pulse(-16'sd32768);
      vec_cnt++; if (acc !== acc_min || acc_sat !== 1'b0) begin $display("FAIL nsat_16: got acc=%0d sat=%0b want %0d 0", acc, acc_sat, acc_min); err_cnt++; end
      pulse(-16'sd32768);
      vec_cnt++; if (acc !== acc_min || acc_sat !== 1'b1) begin $display("FAIL nsat_17: got acc=%0d sat=%0b want %0d 1", acc, acc_sat, acc_min); err_cnt++; end
   endtask

   task automatic test_reset_midstream();
      do_clr();
      pulse(16'sd11);
      pulse(16'sd22);
      vec_cnt++; if (count !== 3'd2) begin $display("FAIL mid_pre_count: got %0d want 2", count); err_cnt++; end
      #2;
      reset = 1'b0;
      #1;
      vec_cnt++; if (out_valid !== 1'b0 || out_data !== 16'sd0 || count !== 3'd0 || acc !== 20'sd0) begin $display("FAIL mid_async: got v=%0b d=%0d count=%0d acc=%0d want 0 0 0 0", out_valid, out_data, count, acc); err_cnt++; end
      done = 1'b1;
      product = 16'sd77;
      tick();
      #2;
      reset = 1'b1;
      tick();
      tick();
      vec_cnt++; if (count !== 3'd0 || acc !== 20'sd0) begin $display("FAIL mid_held_done: got count=%0d acc=%0d want 0 0", count, acc); err_cnt++; end
      done = 1'b0;
      tick();
      pulse(16'sd5);
      vec_cnt++; if (count !== 3'd1 || out_data !== 16'sd5 || acc !== 20'sd5) begin $display("FAIL mid_recapture: got count=%0d d=%0d acc=%0d want 1 5 5", count, out_data, acc); err_cnt++; end
   endtask

   task automatic test_clr_edge();
      product = 16'sd100;
      done    = 1'b1;
      clr     = 1'b1;
      tick();
      clr = 1'b0;
      vec_cnt++; if (count !== 3'd0 || out_valid !== 1'b0 || acc !== 20'sd0) begin $display("FAIL clr_edge: got count=%0d v=%0b acc=%0d want 0 0 0", count, out_valid, acc); err_cnt++; end
      tick();
      tick();
      vec_cnt++; if (count !== 3'd0 || acc !== 20'sd0) begin $display("FAIL clr_edge_consumed: got count=%0d acc=%0d want 0 0", count, acc); err_cnt++; end
      done = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_edge_capture();
      test_full_overflow();
      test_push_pop_full();
      test_saturation();
      test_neg_saturation();
      test_reset_midstream();
      test_clr_edge();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule : tb_mult_result_collector
